// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table and output polarities.
package seg_pkg;

    // Active-high segment patterns {a,b,c,d,e,f,g,dp}, indexed by nibble value.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
        8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK    = 8'hFF;
    localparam logic [7:0] SEG_POL_MASK = 8'hFF;  // XOR mask: active-high pattern -> pin level
    localparam logic       AN_ON        = 1'b0;
    localparam logic       AN_OFF       = 1'b1;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment drive.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = (GLYPH_TABLE[nibble] | {7'b0, dp}) ^ SEG_POL_MASK;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero suppression and per-digit blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [BLK_W-1:0]    blink_cnt_reg, blink_cnt_next;
    logic                blink_phase_reg, blink_phase_next;
    logic [4*DIGITS-1:0] pending_value_reg, active_value_reg, active_value_next;
    logic [DIGITS-1:0]   pending_dp_reg, active_dp_reg, active_dp_next;
    logic                dirty_reg;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic [7:0]          seg_reg, seg_next;
    logic                frame_start_reg;

    logic tick;
    logic boundary;

    assign tick     = (div_cnt_reg == DIV_LAST);
    assign boundary = tick && (idx_reg == IDX_LAST);

    // Outputs are built from next-state values so they change on the same edge as idx.
    always_comb begin
        div_cnt_next      = tick ? '0 : div_cnt_reg + 1'b1;
        idx_next          = idx_reg;
        blink_cnt_next    = blink_cnt_reg;
        blink_phase_next  = blink_phase_reg;
        active_value_next = active_value_reg;
        active_dp_next    = active_dp_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            if (blink_cnt_reg == BLK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end
        if (boundary && dirty_reg) begin
            active_value_next = pending_value_reg;
            active_dp_next    = pending_dp_reg;
        end
    end

    // upper_zero[i]: active nibbles i..DIGITS-1 are all zero
    logic [DIGITS-1:0] upper_zero;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (active_value_next[4*gi +: 4] == 4'h0);
            end else begin : g_mid
                assign upper_zero[gi] = (active_value_next[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
            end
        end
    endgenerate

    logic [3:0] sel_nibble;
    logic       sel_dp;
    logic       sel_blink;
    logic       sel_lz;
    logic [7:0] dec_seg;

    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blink  = 1'b0;
        sel_lz     = 1'b0;
        an_next    = {DIGITS{AN_OFF}};
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                sel_nibble = active_value_next[4*i +: 4];
                sel_dp     = active_dp_next[i];
                sel_blink  = blink_mask[i];
                sel_lz     = (i > 0) && upper_zero[i];
                an_next[i] = AN_ON;
            end
        end
        if (!en) begin
            an_next = {DIGITS{AN_OFF}};
        end
    end

    seg_hex_decode u_dec (
        .nibble (sel_nibble),
        .dp     (sel_dp),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_next = SEG_BLANK;
        if (en) begin
            if (blink_phase_next && sel_blink) begin
                seg_next = SEG_BLANK;
            end else if (lz_en && sel_lz) begin
                seg_next = {7'b0, sel_dp} ^ SEG_POL_MASK;
            end else begin
                seg_next = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg       <= '0;
            idx_reg           <= '0;
            blink_cnt_reg     <= '0;
            blink_phase_reg   <= 1'b0;
            pending_value_reg <= '0;
            pending_dp_reg    <= '0;
            active_value_reg  <= '0;
            active_dp_reg     <= '0;
            dirty_reg         <= 1'b0;
            an_reg            <= {DIGITS{AN_OFF}};
            seg_reg           <= SEG_BLANK;
            frame_start_reg   <= 1'b0;
        end else begin
            div_cnt_reg      <= div_cnt_next;
            idx_reg          <= idx_next;
            blink_cnt_reg    <= blink_cnt_next;
            blink_phase_reg  <= blink_phase_next;
            active_value_reg <= active_value_next;
            active_dp_reg    <= active_dp_next;
            an_reg           <= an_next;
            seg_reg          <= seg_next;
            frame_start_reg  <= boundary;
            // A load on the boundary cycle lands in pending after the copy above and stays dirty.
            if (load) begin
                pending_value_reg <= value;
                pending_dp_reg    <= dp_mask;
                dirty_reg         <= 1'b1;
            end else if (boundary) begin
                dirty_reg <= 1'b0;
            end
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
module tb_seg_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic                clk;
    logic                rst;
    logic                en;
    logic                load;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_en;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                frame_start;

    seg_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .lz_en       (lz_en),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DIGITS-1:0] an;
        logic [7:0]        seg;
        logic              fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared;
    int   n_mismatched;

    logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    // Reference model state
    int                  m_div;
    int                  m_idx;
    int                  m_ticks;
    logic [4*DIGITS-1:0] m_pend_v, m_act_v;
    logic [DIGITS-1:0]   m_pend_d, m_act_d;
    logic                m_dirty;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Advance the model with the inputs currently driven, push the expectation,
    // clock the DUT and compare against the popped expectation.
    task automatic step();
        exp_t e;
        exp_t g;
        logic tick, bnd, phase, upper0;
        logic [3:0] nib;
        logic dp;
        if (rst) begin
            m_div = 0; m_idx = 0; m_ticks = 0;
            m_pend_v = '0; m_act_v = '0; m_pend_d = '0; m_act_d = '0; m_dirty = 1'b0;
            e.an = '1; e.seg = 8'hFF; e.fs = 1'b0;
        end else begin
            tick = (m_div == SCAN_DIV - 1);
            bnd  = tick && (m_idx == DIGITS - 1);
            m_div = tick ? 0 : m_div + 1;
            if (tick) begin
                m_idx = (m_idx + 1) % DIGITS;
                m_ticks++;
            end
            if (bnd && m_dirty) begin
                m_act_v = m_pend_v; m_act_d = m_pend_d; m_dirty = 1'b0;
            end
            if (load) begin
                m_pend_v = value; m_pend_d = dp_mask; m_dirty = 1'b1;
            end
            phase  = ((m_ticks / BLINK_DIV) % 2) == 1;
            nib    = m_act_v[4*m_idx +: 4];
            dp     = m_act_d[m_idx];
            upper0 = ((m_act_v >> (4*m_idx)) == 0);
            e.fs = bnd;
            if (!en) begin
                e.an = '1; e.seg = 8'hFF;
            end else begin
                e.an = ~(DIGITS'(1) << m_idx);
                if (phase && blink_mask[m_idx])
                    e.seg = 8'hFF;
                else if (lz_en && m_idx > 0 && upper0)
                    e.seg = ~{7'b0, dp};
                else
                    e.seg = ~(glyph_tab[nib] | {7'b0, dp});
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
        end else begin
            g = exp_q.pop_front();
            check_val("an", 32'(an), 32'(g.an));
            check_val("seg", 32'(seg), 32'(g.seg));
            check_val("frame_start", 32'(frame_start), 32'(g.fs));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d);
        value = v; dp_mask = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    int fs_count;

    initial begin
        n_compared = 0; n_mismatched = 0;
        rst = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
        blink_mask = '0; lz_en = 1'b0;
        m_div = 0; m_idx = 0; m_ticks = 0; m_dirty = 1'b0;
        m_pend_v = '0; m_act_v = '0; m_pend_d = '0; m_act_d = '0;
        run(3);
        check_val("reset_an", 32'(an), 32'hF);
        check_val("reset_seg", 32'(seg), 32'hFF);
        rst = 1'b0;
        run(2);

        // Basic display with frame_start rate check
        do_load(16'h1234, 4'b0000);
        run(20);
        fs_count = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_start) fs_count++;
        end
        check_val("fs_per_32", 32'(fs_count), 32'd2);

        // Leading-zero suppression, dp shown on a suppressed digit
        lz_en = 1'b1;
        do_load(16'h0070, 4'b0100);
        run(36);
        do_load(16'h0000, 4'b0000);
        run(36);
        lz_en = 1'b0;

        // Load mid-frame, then a second load exactly on the boundary cycle
        do_load(16'hAAAA, 4'b0000);
        begin
            int guard = 0;
            while (!(m_div == SCAN_DIV - 1 && m_idx == DIGITS - 1) && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) check_val("boundary_timeout", 32'd1, 32'd0);
        end
        do_load(16'hBBBB, 4'b1010);
        run(36);

        // Blink
        do_load(16'h5678, 4'b0000);
        blink_mask = 4'b0001;
        run(40);
        blink_mask = 4'b0110;
        run(40);
        blink_mask = 4'b0000;

        // Display disabled while scan and load capture keep running
        en = 1'b0;
        run(3);
        do_load(16'hC0DE, 4'b0001);
        run(6);
        en = 1'b1;
        run(24);

        // Reset mid-frame with a dirty pending load
        do_load(16'hF00F, 4'b1111);
        run(2);
        rst = 1'b1;
        run(1);
        check_val("midrst_an", 32'(an), 32'hF);
        check_val("midrst_seg", 32'(seg), 32'hFF);
        rst = 1'b0;
        run(40);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            lz_en      = $urandom_range(0, 1);
            blink_mask = DIGITS'($urandom);
            value      = 16'($urandom);
            dp_mask    = DIGITS'($urandom);
            load       = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
